// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   AW_DEF               : address width for the default register count
//   reg_adr_t / xlen_t   : address and data types at the default sizes
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_adr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_sb_pending.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared
// at write-back or flush, plus a sticky write-after-write flag and a
// registered count of pending registers.
//   CLK, RST_N           : clock, synchronous active-low reset
//   issue_en, issue_adr  : mark a destination register pending
//   wb_en, wb_adr        : write-back clears the pending bit
//   flush                : clear every pending bit, discard a concurrent issue
//   pending              : pending vector (bit 0 always 0)
//   pend_cnt             : number of pending registers, post-edge
//   waw_err              : sticky, issue hit an already-pending register
module sb_pending
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_adr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_adr,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      pend_cnt,
  output logic             waw_err
);

  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;
  logic             waw_set;

  always_comb begin
    pend_nxt = pending;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (wb_en) pend_nxt[wb_adr] = 1'b0;
      // Applied after the write-back clear so a same-cycle re-issue wins.
      if (issue_en) pend_nxt[issue_adr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end
  end

  // A write-back retiring the same register this cycle makes the re-issue legal.
  assign waw_set = issue_en && (issue_adr != '0) && pending[issue_adr] &&
                   !flush && !(wb_en && (wb_adr == issue_adr));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pending  <= '0;
      pend_cnt <= '0;
      waw_err  <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
      if (waw_set) waw_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational reads, optional write-back forwarding
// and a per-register pending scoreboard for read-after-write detection.
//   CLK, RST_N              : clock, synchronous active-low reset
//   adr1/adr2 -> rs1/rs2    : combinational read ports
//   rs1_busy/rs2_busy       : read register has an outstanding write
//   issue_en, issue_adr     : mark destination of an issuing instruction
//   wb_en, wb_adr, wb_data  : write-back port
//   flush                   : clear all pending bits
//   pend_cnt, waw_err       : pending count, sticky write-after-write flag
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   adr1,
  input  logic [AW-1:0]   adr2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_adr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_adr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     pend_cnt,
  output logic            waw_err
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pending;
  logic             fwd1;
  logic             fwd2;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wb_en && (wb_adr != '0)) begin
      mem[wb_adr] <= wb_data;
    end
  end

  sb_pending #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_pending (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .issue_en  (issue_en),
    .issue_adr (issue_adr),
    .wb_en     (wb_en),
    .wb_adr    (wb_adr),
    .flush     (flush),
    .pending   (pending),
    .pend_cnt  (pend_cnt),
    .waw_err   (waw_err)
  );

  assign fwd1 = (BYPASS != 0) && wb_en && (wb_adr == adr1);
  assign fwd2 = (BYPASS != 0) && wb_en && (wb_adr == adr2);

  always_comb begin
    rs1      = '0;
    rs2      = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (adr1 != '0) begin
      rs1      = fwd1 ? wb_data : mem[adr1];
      // Forwarded data resolves the hazard in the same cycle.
      rs1_busy = pending[adr1] && !fwd1;
    end
    if (adr2 != '0) begin
      rs2      = fwd2 ? wb_data : mem[adr2];
      rs2_busy = pending[adr2] && !fwd2;
    end
  end

endmodule
